// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   alu_op_e        - 4-bit opcode encoding used on in_sel
//   alu_flags_t     - status flags produced alongside every result
//   is_carry_writer - true for opcodes whose carry updates the sticky C register
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_ADC  = 4'd2,
      OP_SBC  = 4'd3,
      OP_MUL  = 4'd4,
      OP_SHL  = 4'd5,
      OP_SHR  = 4'd6,
      OP_ROL  = 4'd7,
      OP_ROR  = 4'd8,
      OP_AND  = 4'd9,
      OP_OR   = 4'd10,
      OP_XOR  = 4'd11,
      OP_NOR  = 4'd12,
      OP_NAND = 4'd13,
      OP_GT   = 4'd14,
      OP_EQ   = 4'd15
   } alu_op_e;

   typedef struct packed {
      logic carry;
      logic zero;
      logic neg;
      logic ovf;
   } alu_flags_t;

   function automatic logic is_carry_writer(alu_op_e op);
      return op inside {OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_MUL};
   endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   a, b     - operands; b[SHW-1:0] is the shift/rotate amount
//   op       - opcode
//   carry_in - sticky carry consumed by ADC/SBC
//   result   - WIDTH-bit result
//   flags    - carry/borrow/shifted-out bit, zero, negative, signed overflow
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_e          op,
   input  logic             carry_in,
   output logic [WIDTH-1:0] result,
   output alu_flags_t       flags
);

   logic [SHW-1:0]       amt;
   logic [SHW-1:0]       rot;
   logic [WIDTH:0]       a_x;
   logic [WIDTH:0]       b_x;
   logic [WIDTH:0]       c_x;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH:0]       shl_x;
   logic [WIDTH:0]       shr_x;
   logic [WIDTH-1:0]     rol_r;
   logic [WIDTH-1:0]     ror_r;
   logic [WIDTH-1:0]     res;
   logic                 cy;
   logic                 ovf;

   assign amt  = b[SHW-1:0];
   // Rotation wraps modulo WIDTH so non-power-of-two widths stay correct.
   assign rot  = SHW'(32'(amt) % WIDTH);
   assign a_x  = {1'b0, a};
   assign b_x  = {1'b0, b};
   assign c_x  = {{WIDTH{1'b0}}, carry_in};
   assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   // One guard bit catches the last bit shifted out; it reads 0 for amt = 0.
   assign shl_x = {1'b0, a} << amt;
   assign shr_x = {a, 1'b0} >> amt;
   assign rol_r = (a << rot) | (a >> (WIDTH - int'(rot)));
   assign ror_r = (a >> rot) | (a << (WIDTH - int'(rot)));

   always_comb begin
      sum = '0;
      res = '0;
      cy  = 1'b0;
      ovf = 1'b0;
      unique case (op)
         OP_ADD: begin
            sum = a_x + b_x;
            res = sum[WIDTH-1:0];
            cy  = sum[WIDTH];
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sum = a_x - b_x;
            res = sum[WIDTH-1:0];
            cy  = sum[WIDTH];
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_ADC: begin
            sum = a_x + b_x + c_x;
            res = sum[WIDTH-1:0];
            cy  = sum[WIDTH];
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SBC: begin
            sum = a_x - b_x - c_x;
            res = sum[WIDTH-1:0];
            cy  = sum[WIDTH];
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_MUL: begin
            res = prod[WIDTH-1:0];
            cy  = |prod[2*WIDTH-1:WIDTH];
         end
         OP_SHL: begin
            res = shl_x[WIDTH-1:0];
            cy  = shl_x[WIDTH];
         end
         OP_SHR: begin
            res = shr_x[WIDTH:1];
            cy  = shr_x[0];
         end
         OP_ROL:  res = rol_r;
         OP_ROR:  res = ror_r;
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_NOR:  res = ~(a | b);
         OP_NAND: res = ~(a & b);
         OP_GT:   res = {{(WIDTH-1){1'b0}}, (a > b)};
         OP_EQ:   res = {{(WIDTH-1){1'b0}}, (a == b)};
         default: res = '0;
      endcase
   end

   assign result      = res;
   assign flags.carry = cy;
   assign flags.zero  = (res == '0);
   assign flags.neg   = res[WIDTH-1];
   assign flags.ovf   = ovf;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides and a
// sticky carry register C for multi-word ADC/SBC chains.
//   clock, reset            - rising-edge clock, synchronous active-low reset
//   in_valid/in_ready       - operand handshake (in_ready combinational)
//   in_a, in_b, in_sel      - operands and opcode
//   out_valid/out_ready     - result handshake
//   out_result, out_carry,
//   out_zero, out_neg,
//   out_ovf                 - registered result and flags
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_ovf
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q,     s1_a_d;
   logic [WIDTH-1:0] s1_b_q,     s1_b_d;
   alu_op_e          s1_op_q,    s1_op_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] result_q,   result_d;
   alu_flags_t       flags_q,    flags_d;
   logic             carry_q,    carry_d;

   logic             en1;
   logic             en2;
   logic [WIDTH-1:0] core_result;
   alu_flags_t       core_flags;

   alu_core #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_core (
      .a        (s1_a_q),
      .b        (s1_b_q),
      .op       (s1_op_q),
      .carry_in (carry_q),
      .result   (core_result),
      .flags    (core_flags)
   );

   always_comb begin
      en2        = !s2_valid_q || out_ready;
      en1        = !s1_valid_q || en2;
      in_ready   = reset && en1;

      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      flags_d    = flags_q;
      carry_d    = carry_q;

      if (en1) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d  = in_a;
            s1_b_d  = in_b;
            s1_op_d = alu_op_e'(in_sel);
         end
      end

      // C is written only as a beat leaves stage 1, so a following ADC/SBC
      // still in stage 1 sees it on the very next cycle.
      if (en2) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d = core_result;
            flags_d  = core_flags;
            if (is_carry_writer(s1_op_q)) begin
               carry_d = core_flags.carry;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= OP_ADD;
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         flags_q    <= '0;
         carry_q    <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_op_q    <= s1_op_d;
         s2_valid_q <= s2_valid_d;
         result_q   <= result_d;
         flags_q    <= flags_d;
         carry_q    <= carry_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_result = result_q;
   assign out_carry  = flags_q.carry;
   assign out_zero   = flags_q.zero;
   assign out_neg    = flags_q.neg;
   assign out_ovf    = flags_q.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe at WIDTH=8: directed vectors with literal
// expectations plus an in-order reference model checked every cycle.
module tb_alu_pipe;

   localparam int W = 8;

   localparam int ADD = 0, SUB = 1, ADC = 2, SBC = 3, MUL = 4, SHL = 5, SHR = 6,
                  ROL = 7, ROR = 8, AND = 9, ORR = 10, XOR = 11, NOR = 12,
                  NAND = 13, GT = 14, EQ = 15;

   logic         clock;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [3:0]   in_sel;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic         out_carry;
   logic         out_zero;
   logic         out_neg;
   logic         out_ovf;

   alu_pipe #(.WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_sel     (in_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_carry  (out_carry),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_ovf    (out_ovf)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      int res;
      int c;
      int z;
      int n;
      int o;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];
   int   mc    = 0;
   exp_t m_e;
   int   m_nc;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Reference: plain integer arithmetic on 8-bit values.
   function automatic exp_t model(input int op, input int a, input int b,
                                  input int cin, output int cout);
      exp_t e;
      int   r;
      int   amt;
      int   a7, b7, r7;
      amt  = b % 8;
      cout = cin;
      e.c  = 0;
      e.o  = 0;
      r    = 0;
      case (op)
         ADD:  begin r = a + b;       e.c = (r > 255); end
         SUB:  begin r = a - b;       e.c = (r < 0);   end
         ADC:  begin r = a + b + cin; e.c = (r > 255); end
         SBC:  begin r = a - b - cin; e.c = (r < 0);   end
         MUL:  begin r = a * b;       e.c = (r > 255); end
         SHL:  begin r = a << amt; e.c = (amt == 0) ? 0 : ((a >> (8 - amt)) & 1); end
         SHR:  begin r = a >> amt; e.c = (amt == 0) ? 0 : ((a >> (amt - 1)) & 1); end
         ROL:  r = (a << amt) | (a >> (8 - amt));
         ROR:  r = (a >> amt) | (a << (8 - amt));
         AND:  r = a & b;
         ORR:  r = a | b;
         XOR:  r = a ^ b;
         NOR:  r = ~(a | b);
         NAND: r = ~(a & b);
         GT:   r = (a > b) ? 1 : 0;
         EQ:   r = (a == b) ? 1 : 0;
         default: r = 0;
      endcase
      e.res = r & 255;
      e.z   = (e.res == 0);
      e.n   = (e.res > 127);
      a7 = (a >> 7) & 1;
      b7 = (b >> 7) & 1;
      r7 = (e.res >> 7) & 1;
      if (op == ADD || op == ADC) e.o = (a7 == b7) && (r7 != a7);
      if (op == SUB || op == SBC) e.o = (a7 != b7) && (r7 != a7);
      if (op <= MUL) cout = e.c;
      return e;
   endfunction

   // Compare process: results must come out in acceptance order.
   always @(negedge clock) begin
      if (!reset) begin
         q.delete();
         mc = 0;
         chk("in_ready_in_reset", int'(in_ready), 0);
      end else begin
         chk("in_ready", int'(in_ready), (q.size() < 2 || out_ready) ? 1 : 0);
         if (out_valid) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_out: got out_valid=1 result %0h, expected no beat", out_result);
            end else begin
               chk("mdl_res",   int'(out_result), q[0].res);
               chk("mdl_carry", int'(out_carry),  q[0].c);
               chk("mdl_zero",  int'(out_zero),   q[0].z);
               chk("mdl_neg",   int'(out_neg),    q[0].n);
               chk("mdl_ovf",   int'(out_ovf),    q[0].o);
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            m_e = model(int'(in_sel), int'(in_a), int'(in_b), mc, m_nc);
            mc  = m_nc;
            q.push_back(m_e);
         end
      end
   end

   task automatic send(input int op, input int a, input int b);
      int n;
      @(posedge clock);
      #1;
      in_valid = 1'b1;
      in_sel   = 4'(op);
      in_a     = 8'(a);
      in_b     = 8'(b);
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) fail_now("send");
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_res(input string name, input int res, input int c,
                             input int z, input int n, input int o, output int lat);
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!out_valid && lat < 20);
      if (!out_valid) fail_now(name);
      else begin
         chk({name, "_res"},   int'(out_result), res);
         chk({name, "_carry"}, int'(out_carry),  c);
         chk({name, "_zero"},  int'(out_zero),   z);
         chk({name, "_neg"},   int'(out_neg),    n);
         chk({name, "_ovf"},   int'(out_ovf),    o);
      end
   endtask

   task automatic op_check(input string name, input int op, input int a, input int b,
                           input int res, input int c, input int z, input int n, input int o);
      int lat;
      send(op, a, b);
      expect_res(name, res, c, z, n, o, lat);
   endtask

   int            lat;
   int            idx;
   int            k;
   int            first_cyc;
   int            last_cyc;
   bit            done;
   logic [7:0]    pat;
   int            t_op [12] = '{ADD, ADC, SUB, SBC, MUL, ADC, SHL, SHR, ROL, ROR, GT, EQ};
   int            t_a  [12] = '{'hC0, 'h50, 'h00, 'h00, 'h13, 'h00, 'hA5, 'hA5, 'h96, 'h96, 'h80, 'h3C};
   int            t_b  [12] = '{'h80, 'h40, 'h01, 'h00, 'h11, 'hFF, 3, 3, 5, 5, 'h7F, 'h3C};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sel    = '0;
      out_ready = 1'b1;

      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_out_valid", int'(out_valid),  0);
      chk("rst_result",    int'(out_result), 0);
      chk("rst_flags",     int'({out_carry, out_zero, out_neg, out_ovf}), 0);
      chk("rst_in_ready",  int'(in_ready),   0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      chk("post_rst_in_ready", int'(in_ready), 1);

      // Directed vectors with hand-computed results.
      send(ADD, 'hFF, 'h01);
      expect_res("add_ff_01", 'h00, 1, 1, 0, 0, lat);
      chk("latency", lat, 2);
      op_check("adc_chain", ADC, 'h00, 'h00, 'h01, 0, 0, 0, 0);
      op_check("sub_5_7",   SUB, 'h05, 'h07, 'hFE, 1, 0, 1, 0);
      op_check("sbc_chain", SBC, 'h10, 'h00, 'h0F, 0, 0, 0, 0);
      op_check("add_ovf",   ADD, 'h7F, 'h01, 'h80, 0, 0, 1, 1);
      op_check("shl_81",    SHL, 'h81, 'h01, 'h02, 1, 0, 0, 0);
      op_check("ror_01",    ROR, 'h01, 'h01, 'h80, 0, 0, 1, 0);
      op_check("shr_01",    SHR, 'h01, 'h01, 'h00, 1, 1, 0, 0);
      op_check("shl_by0",   SHL, 'h55, 'h00, 'h55, 0, 0, 0, 0);
      op_check("mul_hi",    MUL, 'h10, 'h10, 'h00, 1, 1, 0, 0);
      op_check("and_mid",   AND, 'hF0, 'h0F, 'h00, 0, 1, 0, 0);
      op_check("adc_keep",  ADC, 'h00, 'h00, 'h01, 0, 0, 0, 0);
      op_check("gt_5_3",    GT,  'h05, 'h03, 'h01, 0, 0, 0, 0);
      op_check("eq_7_8",    EQ,  'h07, 'h08, 'h00, 0, 1, 0, 0);
      op_check("nand_ff",   NAND,'hFF, 'hFF, 'h00, 0, 1, 0, 0);
      op_check("sbc_ovf",   SBC, 'h80, 'h01, 'h7F, 0, 0, 0, 1);

      // Streamed table under a fixed out_ready pattern, checked by the model.
      pat  = 8'b1011_0110;
      idx  = 0;
      done = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(posedge clock);
         #1;
         out_ready = pat[cyc % 8];
         in_valid  = (idx < 12);
         if (idx < 12) begin
            in_sel = 4'(t_op[idx]);
            in_a   = 8'(t_a[idx]);
            in_b   = 8'(t_b[idx]);
         end
         @(negedge clock);
         if (in_valid && in_ready) idx++;
         done = (idx == 12) && (q.size() == 0) && !out_valid;
      end
      if (!done) fail_now("stream");
      @(posedge clock);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clock);

      // Backpressure: only two beats fit while out_ready is low.
      #1;
      out_ready = 1'b0;
      idx       = 0;
      in_valid  = 1'b1;
      in_sel    = 4'(ADD);
      in_a      = 8'd1;
      in_b      = 8'd1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         chk("bp_in_ready", int'(in_ready), (c < 2) ? 1 : 0);
         if (in_ready) idx++;
         @(posedge clock);
         #1;
         in_a = 8'(idx + 1);
         in_b = 8'(idx + 1);
      end
      chk("bp_held", idx, 2);
      out_ready = 1'b1;
      k         = 0;
      first_cyc = -1;
      last_cyc  = -1;
      for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
         @(negedge clock);
         if (out_valid) begin
            chk("bp_order", int'(out_result), 2 * (k + 1));
            if (k == 0) first_cyc = cyc;
            last_cyc = cyc;
            k++;
         end
         if (in_valid && in_ready) idx++;
         @(posedge clock);
         #1;
         in_valid = (idx < 4);
         in_a     = 8'(idx + 1);
         in_b     = 8'(idx + 1);
      end
      in_valid = 1'b0;
      chk("bp_count",   k, 4);
      chk("bp_accepts", idx, 4);
      chk("bp_span",    last_cyc - first_cyc, 3);
      repeat (2) @(posedge clock);

      // Reset with two beats in flight; the first has already set C.
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 4'(ADD);
      in_a      = 8'hFF;
      in_b      = 8'h01;
      @(posedge clock);
      #1;
      in_a = 8'hFF;
      in_b = 8'hFF;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      reset    = 1'b0;
      @(negedge clock);
      chk("mid_in_ready_low", int'(in_ready), 0);
      @(posedge clock);
      #1;
      reset     = 1'b1;
      out_ready = 1'b1;
      @(negedge clock);
      chk("mid_out_valid", int'(out_valid),  0);
      chk("mid_result",    int'(out_result), 0);
      chk("mid_in_ready",  int'(in_ready),   1);
      op_check("adc_after_rst", ADC, 'h01, 'h01, 'h02, 0, 0, 0, 0);
      repeat (3) @(posedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
